// File: rtl/ecall_unit_if.sv
// Core-facing ecall bus: register taps, writeback path and board I/O for ecall_unit.
// The master is the core/board side; the slave is the ecall unit.
interface ecall_unit_if #(
    parameter int SW_WIDTH = 16
);
    logic                ecall_valid;
    logic [31:0]         a7_data;
    logic [31:0]         a0_data;
    logic [SW_WIDTH-1:0] sw;
    logic                confirm_btn;
    logic                stall;
    logic                ecall_done;
    logic                wb_en;
    logic [4:0]          wb_addr;
    logic [31:0]         wb_data;
    logic [31:0]         disp_data;
    logic                disp_update;
    logic                halted;

    modport master (
        output ecall_valid, a7_data, a0_data, sw, confirm_btn,
        input  stall, ecall_done, wb_en, wb_addr, wb_data, disp_data, disp_update, halted
    );

    modport slave (
        input  ecall_valid, a7_data, a0_data, sw, confirm_btn,
        output stall, ecall_done, wb_en, wb_addr, wb_data, disp_data, disp_update, halted
    );
endinterface

// File: rtl/ecall_unit.sv
// ecall servicing for the single-cycle core: print/read/exit with board I/O; ECALL_SIGN_EXT_EN sign-extends read values.
// Latency: print/unknown retire 2 cycles after ecall_valid; read retires 2 cycles after the accepted confirm edge.
// Backpressure: stall freezes the core from the ecall cycle until DONE; HALT stalls until reset.
module ecall_unit #(
    parameter int SW_WIDTH  = 16,
    parameter int SVC_PRINT = 1,
    parameter int SVC_READ  = 5,
    parameter int SVC_EXIT  = 10
) (
    input logic         clk,
    input logic         rstn,
    ecall_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_IN, WB, DONE, HALT} state_t;

    localparam logic [31:0] CODE_PRINT = 32'(SVC_PRINT);
    localparam logic [31:0] CODE_READ  = 32'(SVC_READ);
    localparam logic [31:0] CODE_EXIT  = 32'(SVC_EXIT);

    state_t      state;
    logic [31:0] a7_lat;
    logic [31:0] a0_lat;
    logic        btn_s1;
    logic        btn_s2;
    logic        btn_prev;
    logic        btn_edge;

    function automatic logic [31:0] ext_sw(input logic [SW_WIDTH-1:0] v);
`ifdef ECALL_SIGN_EXT_EN
        return 32'($signed(v));
`else
        return 32'(v);
`endif
    endfunction

    assign btn_edge  = btn_s2 & ~btn_prev;
    assign bus.stall = (state == DISPATCH) || (state == WAIT_IN) || (state == WB) ||
                       (state == HALT) || ((state == IDLE) && bus.ecall_valid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            a7_lat          <= '0;
            a0_lat          <= '0;
            btn_s1          <= 1'b0;
            btn_s2          <= 1'b0;
            btn_prev        <= 1'b0;
            bus.ecall_done  <= 1'b0;
            bus.wb_en       <= 1'b0;
            bus.wb_addr     <= '0;
            bus.wb_data     <= '0;
            bus.disp_data   <= '0;
            bus.disp_update <= 1'b0;
            bus.halted      <= 1'b0;
        end else begin
            btn_s1          <= bus.confirm_btn;
            btn_s2          <= btn_s1;
            btn_prev        <= btn_s2;
            bus.ecall_done  <= 1'b0;
            bus.disp_update <= 1'b0;
            bus.wb_en       <= 1'b0;
            bus.wb_addr     <= '0;
            case (state)
                IDLE: begin
                    if (bus.ecall_valid) begin
                        a7_lat <= bus.a7_data;
                        a0_lat <= bus.a0_data;
                        state  <= DISPATCH;
                        // Raise halted one cycle early so it is visible in DISPATCH already.
                        if (bus.a7_data == CODE_EXIT) bus.halted <= 1'b1;
                    end
                end
                DISPATCH: begin
                    case (a7_lat)
                        CODE_PRINT: begin
                            bus.disp_data   <= a0_lat;
                            bus.disp_update <= 1'b1;
                            bus.ecall_done  <= 1'b1;
                            state           <= DONE;
                        end
                        CODE_READ: state <= WAIT_IN;
                        CODE_EXIT: state <= HALT;
                        default: begin
                            bus.ecall_done <= 1'b1;
                            state          <= DONE;
                        end
                    endcase
                end
                WAIT_IN: begin
                    if (btn_edge) begin
                        bus.wb_data <= ext_sw(bus.sw);
                        bus.wb_en   <= 1'b1;
                        bus.wb_addr <= 5'd10;
                        state       <= WB;
                    end
                end
                WB: begin
                    bus.wb_data    <= '0;
                    bus.ecall_done <= 1'b1;
                    state          <= DONE;
                end
                // The core advances PC in DONE, so a still-high ecall_valid is stale here.
                DONE:    state <= IDLE;
                HALT:    bus.halted <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
